// File: rtl/exc_ctrl_multi.sv
// Multi-source exception controller: latches rising-edge requests, picks the lowest
// unmasked index, redirects fetch to its vector, saves ELR/ESR and restores PC on ERET.
module exc_ctrl_multi #(
  parameter int              N          = 64,
  parameter int              NUM_SRC    = 4,
  parameter logic [N-1:0]    VEC_BASE   = 64'hD8,
  parameter logic [N-1:0]    VEC_STRIDE = 64'h20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] exc_req,
  input  logic [NUM_SRC-1:0] exc_mask,
  input  logic               eret,
  input  logic               branch_taken,
  input  logic [N-1:0]       imem_addr_F,
  input  logic [N-1:0]       pcbranch_E,
  input  logic [1:0]         sysreg_sel,
  output logic               pcsrc_F,
  output logic [N-1:0]       pcbranch,
  output logic               eproc_F,
  output logic [N-1:0]       exc_vector,
  output logic               squash_F,
  output logic [NUM_SRC-1:0] exc_ack,
  output logic [N-1:0]       elr,
  output logic [7:0]         esr,
  output logic               in_handler,
  output logic [N-1:0]       readData3_E
);

  typedef enum logic [1:0] {IDLE, TAKE, HANDLER} state_t;

  state_t               state;
  logic [3:0]           sel;
  logic [NUM_SRC-1:0]   pend;
  logic [NUM_SRC-1:0]   req_q;
  logic                 take_q;
  logic [NUM_SRC-1:0]   ack_q;
  logic                 handler_q;

  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   elig;
  logic [NUM_SRC-1:0]   take_clr;
  logic [3:0]           prio_idx;
  logic                 eret_acc;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    rise     = exc_req & ~req_q;
    elig     = pend & ~exc_mask;
    take_clr = (state == TAKE) ? (NUM_SRC'(1) << sel) : '0;
    prio_idx = '0;
    // Scan downwards so the lowest eligible index is the one left standing.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) prio_idx = 4'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; only control/status registers are cleared, sel just
    // picks a vector and is cleared purely for determinism.
    if (!reset) begin
      state     <= IDLE;
      sel       <= '0;
      pend      <= '0;
      req_q     <= '0;
      elr       <= '0;
      esr       <= '0;
      take_q    <= 1'b0;
      ack_q     <= '0;
      handler_q <= 1'b0;
    end else begin
      req_q  <= exc_req;
      // A new rising edge on the source being retired wins over its clear.
      pend   <= (pend & ~take_clr) | rise;
      take_q <= 1'b0;
      ack_q  <= '0;
      case (state)
        IDLE: begin
          if (|elig) begin
            state  <= TAKE;
            sel    <= prio_idx;
            take_q <= 1'b1;
            ack_q  <= NUM_SRC'(1) << prio_idx;
          end
        end
        TAKE: begin
          elr       <= imem_addr_F;
          esr       <= {4'b0000, sel + 4'd1};
          state     <= HANDLER;
          handler_q <= 1'b1;
        end
        HANDLER: begin
          if (eret) begin
            state     <= IDLE;
            handler_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          handler_q <= 1'b0;
        end
      endcase
    end
  end

  assign eret_acc    = (state == HANDLER) && eret;
  assign exc_vector  = VEC_BASE + VEC_STRIDE * N'(sel);
  assign eproc_F     = take_q;
  assign squash_F    = take_q;
  assign exc_ack     = ack_q;
  assign in_handler  = handler_q;
  // Branches resolved during TAKE belong to the squashed instruction.
  assign pcsrc_F     = eret_acc || (branch_taken && (state != TAKE));
  assign pcbranch    = eret_acc ? elr : pcbranch_E;

  always_comb begin
    readData3_E = '0;
    case (sysreg_sel)
      2'd0:    readData3_E = elr;
      2'd1:    readData3_E = {{(N-8){1'b0}}, esr};
      2'd2:    readData3_E = exc_vector;
      default: readData3_E = '0;
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl_multi.sv
// Bench for exc_ctrl_multi: directed scenarios plus random traffic, every cycle checked
// against a behavioural model of pending sources, handler mode and saved PC/status.
module tb_exc_ctrl_multi;
  localparam int N  = 64;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NS-1:0] exc_req, exc_mask;
  logic          eret, branch_taken;
  logic [N-1:0]  imem_addr_F, pcbranch_E;
  logic [1:0]    sysreg_sel;
  logic          pcsrc_F, eproc_F, squash_F, in_handler;
  logic [N-1:0]  pcbranch, exc_vector, elr, readData3_E;
  logic [NS-1:0] exc_ack;
  logic [7:0]    esr;

  always #5 clk = ~clk;

  exc_ctrl_multi #(.N(N), .NUM_SRC(NS)) dut (
    .clk(clk), .reset(reset), .exc_req(exc_req), .exc_mask(exc_mask),
    .eret(eret), .branch_taken(branch_taken), .imem_addr_F(imem_addr_F),
    .pcbranch_E(pcbranch_E), .sysreg_sel(sysreg_sel), .pcsrc_F(pcsrc_F),
    .pcbranch(pcbranch), .eproc_F(eproc_F), .exc_vector(exc_vector),
    .squash_F(squash_F), .exc_ack(exc_ack), .elr(elr), .esr(esr),
    .in_handler(in_handler), .readData3_E(readData3_E)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt = 0;

  // Model: which sources are waiting, what mode the controller is in, what was saved.
  bit [NS-1:0]  m_pend, m_prev;
  int           m_mode;   // 0 = idle, 1 = taking, 2 = in handler
  int           m_sel;
  logic [63:0]  m_elr;
  logic [7:0]   m_esr;
  bit           m_taken;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [63:0] vec;
    bit          take, hnd, acc;
    vec  = 64'hD8 + 64'(m_sel) * 64'h20;
    take = (m_mode == 1);
    hnd  = (m_mode == 2);
    acc  = hnd && eret;
    if (exc_ack != '0) ack_cnt++;
    check("eproc_F", 64'(eproc_F), 64'(take));
    check("squash_F", 64'(squash_F), 64'(take));
    check("exc_ack", 64'(exc_ack), take ? (64'd1 << m_sel) : 64'd0);
    check("in_handler", 64'(in_handler), 64'(hnd));
    if (take) check("exc_vector", exc_vector, vec);
    check("pcsrc_F", 64'(pcsrc_F), acc ? 64'd1 : (take ? 64'd0 : 64'(branch_taken)));
    check("pcbranch", pcbranch, acc ? m_elr : pcbranch_E);
    check("elr", elr, m_elr);
    check("esr", 64'(esr), 64'(m_esr));
    case (sysreg_sel)
      2'd0: check("rd3_elr", readData3_E, m_elr);
      2'd1: check("rd3_esr", readData3_E, 64'(m_esr));
      2'd2: if (m_taken) check("rd3_vec", readData3_E, vec);
      default: check("rd3_zero", readData3_E, 64'd0);
    endcase
  endtask

  task automatic model_edge();
    bit [NS-1:0] rise;
    bit          found;
    if (!reset) begin
      m_pend = '0; m_prev = '0; m_mode = 0; m_sel = 0;
      m_elr = '0; m_esr = '0; m_taken = 1'b0;
    end else begin
      rise  = exc_req & ~m_prev;
      found = 1'b0;
      case (m_mode)
        0: for (int i = 0; i < NS; i++) begin
             if (!found && m_pend[i] && !exc_mask[i]) begin
               found = 1'b1; m_mode = 1; m_sel = i; m_taken = 1'b1;
             end
           end
        1: begin
             m_pend[m_sel] = 1'b0;
             m_elr  = imem_addr_F;
             m_esr  = 8'(m_sel + 1);
             m_mode = 2;
           end
        default: if (eret) m_mode = 0;
      endcase
      m_pend = m_pend | rise;
      m_prev = exc_req;
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance the model on the edge.
  task automatic cyc(input bit r, input logic [NS-1:0] req, input logic [NS-1:0] mask,
                     input bit er, input bit bt, input logic [63:0] pc,
                     input logic [63:0] pce, input logic [1:0] ss);
    @(negedge clk);
    reset = r; exc_req = req; exc_mask = mask; eret = er; branch_taken = bt;
    imem_addr_F = pc; pcbranch_E = pce; sysreg_sel = ss;
    #1;
    compare_all();
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    reset = 1'b0; exc_req = '0; exc_mask = '0; eret = 1'b0; branch_taken = 1'b0;
    imem_addr_F = '0; pcbranch_E = '0; sysreg_sel = 2'd0;
    repeat (2) @(posedge clk);
    model_edge();

    // Reset state observed, then a single request on source 0 at PC 0x40.
    cyc(0, 4'b0000, 4'b0000, 0, 0, 64'h0, 64'h0, 2'd0);
    cyc(1, 4'b0001, 4'b0000, 0, 0, 64'h40, 64'h0, 2'd1);
    cyc(1, 4'b0001, 4'b0000, 0, 0, 64'h40, 64'h0, 2'd1);
    #1;
    check("single_vec", exc_vector, 64'hD8);
    check("single_ack", 64'(exc_ack), 64'h1);
    cyc(1, 4'b0001, 4'b0000, 0, 0, 64'h40, 64'h0, 2'd1);
    #1;
    check("single_elr", elr, 64'h40);
    check("single_esr", 64'(esr), 64'h01);
    // ERET with a taken branch in the same cycle, then the same pair while idle.
    cyc(1, 4'b0000, 4'b0000, 1, 1, 64'h44, 64'h80, 2'd0);
    cyc(1, 4'b0000, 4'b0000, 1, 1, 64'h40, 64'h80, 2'd2);

    // Sources 3 and 1 rise together.
    cyc(1, 4'b1010, 4'b0000, 0, 0, 64'h100, 64'h0, 2'd0);
    cyc(1, 4'b1010, 4'b0000, 0, 0, 64'h100, 64'h0, 2'd0);
    #1;
    check("prio_first_vec", exc_vector, 64'hF8);
    cyc(1, 4'b1010, 4'b0000, 0, 0, 64'h100, 64'h0, 2'd1);
    #1;
    check("prio_first_esr", 64'(esr), 64'h02);
    cyc(1, 4'b0000, 4'b0000, 1, 0, 64'h104, 64'h0, 2'd1);
    cyc(1, 4'b0000, 4'b0000, 0, 0, 64'h100, 64'h0, 2'd1);
    #1;
    check("prio_second_vec", exc_vector, 64'h138);
    cyc(1, 4'b0000, 4'b0000, 0, 0, 64'h100, 64'h0, 2'd2);
    #1;
    check("prio_second_esr", 64'(esr), 64'h04);
    cyc(1, 4'b0000, 4'b0000, 1, 0, 64'h108, 64'h0, 2'd0);

    // Masked source 2 waits ten cycles, then is taken once unmasked.
    cyc(1, 4'b0100, 4'b0100, 0, 0, 64'h200, 64'h0, 2'd0);
    for (int i = 0; i < 10; i++) cyc(1, 4'b0000, 4'b0100, 0, 0, 64'h200, 64'h0, 2'd0);
    cyc(1, 4'b0000, 4'b0000, 0, 0, 64'h200, 64'h0, 2'd2);
    #1;
    check("mask_vec", exc_vector, 64'h118);
    cyc(1, 4'b0000, 4'b0000, 0, 0, 64'h200, 64'h0, 2'd2);
    cyc(1, 4'b0000, 4'b0000, 1, 0, 64'h204, 64'h0, 2'd2);

    // Source 0 held high for 20 cycles across take, handler and ERET.
    ack_cnt = 0;
    for (int i = 0; i < 20; i++) cyc(1, 4'b0001, 4'b0000, (i == 8), 0, 64'h300, 64'h0, 2'd0);
    check("held_acks", 64'(ack_cnt), 64'd1);
    #1;
    check("held_idle", 64'(in_handler), 64'd0);

    // Reset while in the handler with another source pending.
    cyc(1, 4'b0000, 4'b0000, 0, 0, 64'h400, 64'h0, 2'd0);
    cyc(1, 4'b0001, 4'b0000, 0, 0, 64'h400, 64'h0, 2'd0);
    cyc(1, 4'b0001, 4'b0000, 0, 0, 64'h400, 64'h0, 2'd0);
    cyc(1, 4'b0011, 4'b0000, 0, 0, 64'h400, 64'h0, 2'd0);
    cyc(1, 4'b0011, 4'b0000, 0, 0, 64'h400, 64'h0, 2'd0);
    cyc(0, 4'b0000, 4'b0000, 0, 0, 64'h400, 64'h0, 2'd0);
    #1;
    check("rst_in_handler", 64'(in_handler), 64'd0);
    check("rst_elr", elr, 64'd0);
    check("rst_esr", 64'(esr), 64'd0);
    cyc(1, 4'b0000, 4'b0000, 0, 0, 64'h400, 64'h0, 2'd0);
    #1;
    check("rst_no_take", 64'(eproc_F), 64'd0);

    // Random traffic: sparse request toggles, occasional masks, ERETs and resets.
    for (int c = 0; c < 1500; c++) begin
      logic [NS-1:0] flip, mask;
      for (int b = 0; b < NS; b++) flip[b] = ($urandom_range(0, 7) == 0);
      mask = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
      cyc(($urandom_range(0, 299) != 0), exc_req ^ flip, mask,
          ($urandom_range(0, 3) == 0), 1'($urandom),
          {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
